// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one line-granular read/write request from the cache
// arbiter into a fixed-length burst (BURST_LEN beats of BURST_WIDTH bits) on the
// physical memory interface. One transaction in flight, no queuing.
// Optional performance counters are compiled in with CACHELINE_ADAPTOR_PERF_EN.
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int BURST_LEN   = LINE_WIDTH / BURST_WIDTH,
    parameter int OFFSET_BITS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    // arbiter side
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    // memory side
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
   ,output logic [31:0]            perf_reads_o,
    output logic [31:0]            perf_writes_o,
    output logic [31:0]            perf_stall_o
`endif
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                                state, state_nxt;
    logic [CNT_W-1:0]                      cnt;
    logic [BURST_LEN-1:0][BURST_WIDTH-1:0] rbuf;   // read line, beat-indexed
    logic [BURST_LEN-1:0][BURST_WIDTH-1:0] wbuf;   // write line captured at accept
    logic [31:0]                           addr;
    logic                                  last_beat;
    logic                                  unused_offset;

    // Offset bits are discarded by the line alignment.
    assign unused_offset = ^address_i[OFFSET_BITS-1:0];

    // Beat on the wire this cycle is the final one of the burst.
    assign last_beat = resp_i && (cnt == CNT_W'(BURST_LEN - 1));

    // Read data is exposed continuously; the arbiter samples it only at resp_o.
    assign line_o = rbuf;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and all burst/handshake outputs, decoded from the state.
    always_comb begin
        state_nxt = state;
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        address_o = '0;
        burst_o   = '0;
        case (state)
            IDLE: begin
                // Writes win if both are raised.
                if (write_i)     state_nxt = WRITE;
                else if (read_i) state_nxt = READ;
            end
            READ: begin
                read_o    = 1'b1;
                address_o = addr;
                if (last_beat) state_nxt = DONE;
            end
            WRITE: begin
                write_o   = 1'b1;
                address_o = addr;
                burst_o   = wbuf[cnt];
                if (last_beat) state_nxt = DONE;
            end
            DONE: begin
                resp_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, beat counter and read-line assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            addr <= '0;
            rbuf <= '0;
            wbuf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i || read_i) begin
                        addr <= {address_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        cnt  <= '0;
                    end
                    if (write_i) wbuf <= line_i;
                end
                READ: begin
                    if (resp_i) begin
                        rbuf[cnt] <= burst_i;
                        cnt       <= last_beat ? '0 : cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    if (resp_i) cnt <= last_beat ? '0 : cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef CACHELINE_ADAPTOR_PERF_EN
    // Saturating transaction and stall counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_reads_o  <= '0;
            perf_writes_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (state == READ && last_beat && perf_reads_o != '1)
                perf_reads_o <= perf_reads_o + 32'd1;
            if (state == WRITE && last_beat && perf_writes_o != '1)
                perf_writes_o <= perf_writes_o + 32'd1;
            if ((state == READ || state == WRITE) && !resp_i && perf_stall_o != '1)
                perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
